// File: rtl/rv_pkg.sv
// Shared RV32I definitions: datapath width, base opcodes and immediate formats.
// Used by the decode stage and its immediate generator.
package rv_pkg;

  localparam int XLEN = 32;

  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;

  typedef enum logic [2:0] {
    IMM_I,
    IMM_S,
    IMM_B,
    IMM_U,
    IMM_J,
    IMM_NONE
  } imm_type_e;

  // R-type and unrecognised opcodes carry no immediate.
  function automatic imm_type_e immTypeOf(input logic [6:0] opcode);
    imm_type_e t;
    case (opcode)
      OPC_LOAD, OPC_OP_IMM, OPC_JALR: t = IMM_I;
      OPC_STORE:                      t = IMM_S;
      OPC_BRANCH:                     t = IMM_B;
      OPC_LUI, OPC_AUIPC:             t = IMM_U;
      OPC_JAL:                        t = IMM_J;
      default:                        t = IMM_NONE;
    endcase
    return t;
  endfunction

endpackage

// File: rtl/imm_gen.sv
// Combinational RV32I immediate generator: rebuilds the sign-extended
// immediate of the instruction's format.
module imm_gen #(
  parameter int XLEN = rv_pkg::XLEN
) (
  input  logic [31:0]     i_ins,
  output logic [XLEN-1:0] o_imm
);
  import rv_pkg::*;

  imm_type_e   w_type;
  logic [31:0] w_imm32;
  logic        w_sign;

  assign w_type = immTypeOf(i_ins[6:0]);
  assign w_sign = i_ins[31];

  always_comb begin
    w_imm32 = '0;
    case (w_type)
      IMM_I:   w_imm32 = {{20{w_sign}}, i_ins[31:20]};
      IMM_S:   w_imm32 = {{20{w_sign}}, i_ins[31:25], i_ins[11:7]};
      IMM_B:   w_imm32 = {{19{w_sign}}, i_ins[31], i_ins[7], i_ins[30:25], i_ins[11:8], 1'b0};
      IMM_U:   w_imm32 = {i_ins[31:12], 12'b0};
      IMM_J:   w_imm32 = {{11{w_sign}}, i_ins[31], i_ins[19:12], i_ins[20], i_ins[30:21], 1'b0};
      default: w_imm32 = '0;
    endcase
  end

  // Wider datapaths keep extending the sign bit.
  assign o_imm = XLEN'($signed(w_imm32));

endmodule

// File: rtl/id_ex_stage.sv
// RV32I decode stage plus ID/EX pipeline register: register-file addressing,
// write-back bypass, load-use stall/bubble insertion and a stall counter.
module id_ex_stage #(
  parameter int XLEN  = rv_pkg::XLEN,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  input  logic [31:0]      in_ins,
  input  logic [XLEN-1:0]  in_pc,
  output logic [4:0]       rn1,
  output logic [4:0]       rn2,
  input  logic [XLEN-1:0]  rd1,
  input  logic [XLEN-1:0]  rd2,
  input  logic             wb_w,
  input  logic [4:0]       wb_wn,
  input  logic [XLEN-1:0]  wb_wd,
  input  logic             flush,
  input  logic             hold,
  output logic             stall,
  output logic             ex_valid,
  output logic [XLEN-1:0]  ex_pc,
  output logic [XLEN-1:0]  ex_a,
  output logic [XLEN-1:0]  ex_b,
  output logic [XLEN-1:0]  ex_imm,
  output logic [4:0]       ex_rd,
  output logic [6:0]       ex_opcode,
  output logic [2:0]       ex_funct3,
  output logic             ex_f7b5,
  output logic             ex_is_load,
  output logic             ex_regwrite,
  output logic [CNT_W-1:0] stall_count
);
  import rv_pkg::*;

  logic [6:0]       w_opcode;
  logic [4:0]       w_rd;
  logic [XLEN-1:0]  w_imm;
  logic [XLEN-1:0]  w_srcA;
  logic [XLEN-1:0]  w_srcB;
  logic             w_usesRs1;
  logic             w_usesRs2;
  logic             w_writesRd;
  logic             w_isLoad;
  logic             w_loadUse;

  logic             r_exValid;
  logic [XLEN-1:0]  r_exPc;
  logic [XLEN-1:0]  r_exA;
  logic [XLEN-1:0]  r_exB;
  logic [XLEN-1:0]  r_exImm;
  logic [4:0]       r_exRd;
  logic [6:0]       r_exOpcode;
  logic [2:0]       r_exFunct3;
  logic             r_exF7b5;
  logic             r_exIsLoad;
  logic             r_exRegwrite;
  logic [CNT_W-1:0] r_stallCount;

  assign w_opcode = in_ins[6:0];
  assign w_rd     = in_ins[11:7];
  assign rn1      = in_ins[19:15];
  assign rn2      = in_ins[24:20];

  imm_gen #(.XLEN(XLEN)) u_imm_gen (
    .i_ins (in_ins),
    .o_imm (w_imm)
  );

  // x0 always reads as zero; otherwise the value being written back this cycle wins.
  assign w_srcA = (rn1 == 5'd0) ? '0 :
                  (wb_w && wb_wn != 5'd0 && wb_wn == rn1) ? wb_wd : rd1;
  assign w_srcB = (rn2 == 5'd0) ? '0 :
                  (wb_w && wb_wn != 5'd0 && wb_wn == rn2) ? wb_wd : rd2;

  assign w_usesRs1 = !(w_opcode == OPC_LUI || w_opcode == OPC_AUIPC || w_opcode == OPC_JAL);
  assign w_usesRs2 = (w_opcode == OPC_OP || w_opcode == OPC_STORE || w_opcode == OPC_BRANCH);
  assign w_isLoad  = (w_opcode == OPC_LOAD);

  always_comb begin
    w_writesRd = 1'b0;
    case (w_opcode)
      OPC_OP, OPC_OP_IMM, OPC_LOAD, OPC_LUI,
      OPC_AUIPC, OPC_JAL, OPC_JALR: w_writesRd = (w_rd != 5'd0);
      default:                      w_writesRd = 1'b0;
    endcase
  end

  assign w_loadUse = in_valid && r_exValid && r_exIsLoad && (r_exRd != 5'd0) &&
                     ((w_usesRs1 && r_exRd == rn1) || (w_usesRs2 && r_exRd == rn2));

  // Flush overrides both hold and the load-use stall.
  assign stall = rst_n && !flush && (hold || w_loadUse);

  always_ff @(posedge clk) begin
    if (!rst_n || flush) begin
      r_exValid    <= 1'b0;
      r_exPc       <= '0;
      r_exA        <= '0;
      r_exB        <= '0;
      r_exImm      <= '0;
      r_exRd       <= '0;
      r_exOpcode   <= '0;
      r_exFunct3   <= '0;
      r_exF7b5     <= 1'b0;
      r_exIsLoad   <= 1'b0;
      r_exRegwrite <= 1'b0;
      if (!rst_n) begin
        r_stallCount <= '0;
      end
    end else if (hold) begin
      r_exValid <= r_exValid;
    end else if (w_loadUse) begin
      r_exValid    <= 1'b0;
      r_exIsLoad   <= 1'b0;
      r_exRegwrite <= 1'b0;
      if (r_stallCount != {CNT_W{1'b1}}) begin
        r_stallCount <= r_stallCount + CNT_W'(1);
      end
    end else begin
      r_exValid    <= in_valid;
      r_exPc       <= in_pc;
      r_exA        <= w_srcA;
      r_exB        <= w_srcB;
      r_exImm      <= w_imm;
      r_exRd       <= w_rd;
      r_exOpcode   <= w_opcode;
      r_exFunct3   <= in_ins[14:12];
      r_exF7b5     <= in_ins[30];
      r_exIsLoad   <= in_valid && w_isLoad;
      r_exRegwrite <= in_valid && w_writesRd;
    end
  end

  assign ex_valid    = r_exValid;
  assign ex_pc       = r_exPc;
  assign ex_a        = r_exA;
  assign ex_b        = r_exB;
  assign ex_imm      = r_exImm;
  assign ex_rd       = r_exRd;
  assign ex_opcode   = r_exOpcode;
  assign ex_funct3   = r_exFunct3;
  assign ex_f7b5     = r_exF7b5;
  assign ex_is_load  = r_exIsLoad;
  assign ex_regwrite = r_exRegwrite;
  assign stall_count = r_stallCount;

endmodule

// File: tb/tb_id_ex_stage.sv
// Directed bench for id_ex_stage; a second instance with a 4-bit stall
// counter shares the stimulus so counter saturation is reachable quickly.
module tb_id_ex_stage;

  localparam logic [31:0] INS_ADDI = 32'h00700293;
  localparam logic [31:0] INS_LW   = 32'h0002A303;
  localparam logic [31:0] INS_ADD  = 32'h005303B3;
  localparam logic [31:0] INS_SW   = 32'h0072A223;
  localparam logic [31:0] INS_BEQ  = 32'hFE000CE3;
  localparam logic [31:0] INS_LUI  = 32'h123450B7;
  localparam logic [31:0] INS_JAL  = 32'hFFDFF0EF;
  localparam logic [31:0] INS_SUB  = 32'h403100B3;
  localparam logic [31:0] INS_UNK  = 32'h000002FF;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid;
  logic [31:0] in_ins;
  logic [31:0] in_pc;
  logic [31:0] rd1, rd2, wb_wd;
  logic        wb_w;
  logic [4:0]  wb_wn;
  logic        flush, hold;

  logic [4:0]  rn1, rn2;
  logic        stall, ex_valid, ex_f7b5, ex_is_load, ex_regwrite;
  logic [31:0] ex_pc, ex_a, ex_b, ex_imm;
  logic [4:0]  ex_rd;
  logic [6:0]  ex_opcode;
  logic [2:0]  ex_funct3;
  logic [15:0] stall_count;

  logic [4:0]  s_rn1, s_rn2;
  logic        s_stall, s_ex_valid, s_ex_f7b5, s_ex_is_load, s_ex_regwrite;
  logic [31:0] s_ex_pc, s_ex_a, s_ex_b, s_ex_imm;
  logic [4:0]  s_ex_rd;
  logic [6:0]  s_ex_opcode;
  logic [2:0]  s_ex_funct3;
  logic [3:0]  s_stall_count;

  int checks = 0;
  int errors = 0;
  int expCount = 0;
  logic [3:0] expSat;

  always #5 clk = ~clk;

  id_ex_stage dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ins(in_ins), .in_pc(in_pc),
    .rn1(rn1), .rn2(rn2), .rd1(rd1), .rd2(rd2),
    .wb_w(wb_w), .wb_wn(wb_wn), .wb_wd(wb_wd), .flush(flush), .hold(hold),
    .stall(stall), .ex_valid(ex_valid), .ex_pc(ex_pc), .ex_a(ex_a), .ex_b(ex_b),
    .ex_imm(ex_imm), .ex_rd(ex_rd), .ex_opcode(ex_opcode), .ex_funct3(ex_funct3),
    .ex_f7b5(ex_f7b5), .ex_is_load(ex_is_load), .ex_regwrite(ex_regwrite),
    .stall_count(stall_count)
  );

  id_ex_stage #(.CNT_W(4)) dut_sat (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ins(in_ins), .in_pc(in_pc),
    .rn1(s_rn1), .rn2(s_rn2), .rd1(rd1), .rd2(rd2),
    .wb_w(wb_w), .wb_wn(wb_wn), .wb_wd(wb_wd), .flush(flush), .hold(hold),
    .stall(s_stall), .ex_valid(s_ex_valid), .ex_pc(s_ex_pc), .ex_a(s_ex_a), .ex_b(s_ex_b),
    .ex_imm(s_ex_imm), .ex_rd(s_ex_rd), .ex_opcode(s_ex_opcode), .ex_funct3(s_ex_funct3),
    .ex_f7b5(s_ex_f7b5), .ex_is_load(s_ex_is_load), .ex_regwrite(s_ex_regwrite),
    .stall_count(s_stall_count)
  );

  task tick;
    @(posedge clk);
    #1;
  endtask

  task applyIdle;
    in_valid = 1'b0; in_ins = 32'h00000013; in_pc = 32'h0;
    rd1 = '0; rd2 = '0; wb_w = 1'b0; wb_wn = '0; wb_wd = '0;
    flush = 1'b0; hold = 1'b0;
  endtask

  task test_reset;
    rst_n = 1'b0;
    applyIdle();
    tick(); tick();
    checks++; if (ex_valid !== 1'b0) begin errors++; $display("[TB] FAIL reset_valid got %0b exp 0", ex_valid); end
    checks++; if (stall_count !== 16'h0) begin errors++; $display("[TB] FAIL reset_count got %h exp 0000", stall_count); end
    checks++; if (ex_imm !== 32'h0) begin errors++; $display("[TB] FAIL reset_imm got %h exp 0", ex_imm); end
    checks++; if (stall !== 1'b0) begin errors++; $display("[TB] FAIL reset_stall got %0b exp 0", stall); end
    rst_n = 1'b1;
  endtask

  task test_addi;
    in_valid = 1'b1; in_ins = INS_ADDI; in_pc = 32'h100; rd1 = 32'h55;
    #1;
    checks++; if (rn1 !== 5'd0 || rn2 !== 5'd7) begin errors++; $display("[TB] FAIL addi_rn got %0d/%0d exp 0/7", rn1, rn2); end
    checks++; if (stall !== 1'b0) begin errors++; $display("[TB] FAIL addi_stall got %0b exp 0", stall); end
    tick();
    checks++; if (ex_valid !== 1'b1) begin errors++; $display("[TB] FAIL addi_valid got %0b exp 1", ex_valid); end
    checks++; if (ex_rd !== 5'd5) begin errors++; $display("[TB] FAIL addi_rd got %0d exp 5", ex_rd); end
    checks++; if (ex_imm !== 32'd7) begin errors++; $display("[TB] FAIL addi_imm got %h exp 7", ex_imm); end
    checks++; if (ex_a !== 32'd0) begin errors++; $display("[TB] FAIL addi_a got %h exp 0", ex_a); end
    checks++; if (ex_regwrite !== 1'b1) begin errors++; $display("[TB] FAIL addi_regwrite got %0b exp 1", ex_regwrite); end
    checks++; if (ex_pc !== 32'h100) begin errors++; $display("[TB] FAIL addi_pc got %h exp 100", ex_pc); end
    checks++; if (ex_opcode !== 7'h13) begin errors++; $display("[TB] FAIL addi_opcode got %h exp 13", ex_opcode); end
  endtask

  task test_load_use;
    in_ins = INS_LW; in_pc = 32'h104; rd1 = 32'd7;
    tick();
    checks++; if (ex_is_load !== 1'b1 || ex_rd !== 5'd6) begin errors++; $display("[TB] FAIL lw_ex got load=%0b rd=%0d exp 1/6", ex_is_load, ex_rd); end
    checks++; if (ex_a !== 32'd7) begin errors++; $display("[TB] FAIL lw_a got %h exp 7", ex_a); end
    in_ins = INS_ADD; in_pc = 32'h108; rd1 = 32'h66; rd2 = 32'd7;
    #1;
    checks++; if (stall !== 1'b1) begin errors++; $display("[TB] FAIL lu_stall got %0b exp 1", stall); end
    tick(); expCount++;
    checks++; if (ex_valid !== 1'b0 || ex_regwrite !== 1'b0 || ex_is_load !== 1'b0) begin errors++; $display("[TB] FAIL lu_bubble got v=%0b w=%0b l=%0b exp 0/0/0", ex_valid, ex_regwrite, ex_is_load); end
    checks++; if (stall_count !== 16'd1) begin errors++; $display("[TB] FAIL lu_count got %0d exp 1", stall_count); end
    checks++; if (stall !== 1'b0) begin errors++; $display("[TB] FAIL lu_release got %0b exp 0", stall); end
    tick();
    checks++; if (ex_valid !== 1'b1 || ex_rd !== 5'd7) begin errors++; $display("[TB] FAIL add_enter got v=%0b rd=%0d exp 1/7", ex_valid, ex_rd); end
    checks++; if (ex_a !== 32'h66 || ex_b !== 32'd7) begin errors++; $display("[TB] FAIL add_ops got %h/%h exp 66/7", ex_a, ex_b); end
    checks++; if (ex_imm !== 32'h0 || ex_pc !== 32'h108) begin errors++; $display("[TB] FAIL add_imm_pc got %h/%h exp 0/108", ex_imm, ex_pc); end
  endtask

  task test_bypass;
    in_ins = INS_SW; rd1 = 32'd7; rd2 = 32'h77;
    wb_w = 1'b1; wb_wn = 5'd5; wb_wd = 32'h12345678;
    tick();
    checks++; if (ex_a !== 32'h12345678) begin errors++; $display("[TB] FAIL byp_a got %h exp 12345678", ex_a); end
    checks++; if (ex_b !== 32'h77) begin errors++; $display("[TB] FAIL byp_b got %h exp 77", ex_b); end
    checks++; if (ex_imm !== 32'd4 || ex_funct3 !== 3'd2) begin errors++; $display("[TB] FAIL sw_imm got %h f3=%0d exp 4/2", ex_imm, ex_funct3); end
    checks++; if (ex_regwrite !== 1'b0) begin errors++; $display("[TB] FAIL sw_regwrite got %0b exp 0", ex_regwrite); end
    wb_wn = 5'd0;
    tick();
    checks++; if (ex_a !== 32'd7) begin errors++; $display("[TB] FAIL nobyp_a got %h exp 7", ex_a); end
    wb_wn = 5'd7;
    tick();
    checks++; if (ex_a !== 32'd7 || ex_b !== 32'h12345678) begin errors++; $display("[TB] FAIL byp_b7 got %h/%h exp 7/12345678", ex_a, ex_b); end
    wb_w = 1'b0;
    tick();
    checks++; if (ex_b !== 32'h77) begin errors++; $display("[TB] FAIL byp_off got %h exp 77", ex_b); end
  endtask

  task test_branch;
    in_ins = INS_BEQ; rd1 = 32'hDEADBEEF; rd2 = 32'hDEADBEEF;
    wb_w = 1'b1; wb_wn = 5'd0; wb_wd = 32'h11;
    tick();
    checks++; if (ex_imm !== 32'hFFFFFFF8) begin errors++; $display("[TB] FAIL beq_imm got %h exp FFFFFFF8", ex_imm); end
    checks++; if (ex_a !== 32'h0 || ex_b !== 32'h0) begin errors++; $display("[TB] FAIL beq_x0 got %h/%h exp 0/0", ex_a, ex_b); end
    checks++; if (ex_regwrite !== 1'b0 || ex_valid !== 1'b1) begin errors++; $display("[TB] FAIL beq_ctl got w=%0b v=%0b exp 0/1", ex_regwrite, ex_valid); end
    wb_w = 1'b0;
  endtask

  task test_imm_formats;
    in_ins = INS_LUI;
    tick();
    checks++; if (ex_imm !== 32'h12345000 || ex_regwrite !== 1'b1 || ex_rd !== 5'd1) begin errors++; $display("[TB] FAIL lui got %h w=%0b rd=%0d exp 12345000/1/1", ex_imm, ex_regwrite, ex_rd); end
    in_ins = INS_JAL;
    tick();
    checks++; if (ex_imm !== 32'hFFFFFFFC || ex_regwrite !== 1'b1) begin errors++; $display("[TB] FAIL jal got %h w=%0b exp FFFFFFFC/1", ex_imm, ex_regwrite); end
    in_ins = INS_SUB;
    tick();
    checks++; if (ex_f7b5 !== 1'b1 || ex_imm !== 32'h0) begin errors++; $display("[TB] FAIL sub got f7b5=%0b imm=%h exp 1/0", ex_f7b5, ex_imm); end
    in_ins = INS_UNK;
    tick();
    checks++; if (ex_valid !== 1'b1 || ex_regwrite !== 1'b0 || ex_imm !== 32'h0) begin errors++; $display("[TB] FAIL unknown got v=%0b w=%0b imm=%h exp 1/0/0", ex_valid, ex_regwrite, ex_imm); end
    in_ins = INS_ADDI; in_valid = 1'b0;
    tick();
    checks++; if (ex_valid !== 1'b0 || ex_regwrite !== 1'b0) begin errors++; $display("[TB] FAIL invalid got v=%0b w=%0b exp 0/0", ex_valid, ex_regwrite); end
    in_valid = 1'b1;
  endtask

  task test_flush_hold;
    in_ins = INS_LW; in_pc = 32'h200;
    tick();
    in_ins = INS_ADD; in_pc = 32'h204; flush = 1'b1;
    #1;
    checks++; if (stall !== 1'b0) begin errors++; $display("[TB] FAIL flush_stall got %0b exp 0", stall); end
    tick();
    checks++; if (ex_valid !== 1'b0 || stall_count !== 16'(expCount)) begin errors++; $display("[TB] FAIL flush_ex got v=%0b cnt=%0d exp 0/%0d", ex_valid, stall_count, expCount); end
    flush = 1'b0; in_ins = INS_LW; in_pc = 32'h300;
    tick();
    in_ins = INS_ADD; in_pc = 32'h304; hold = 1'b1;
    #1;
    checks++; if (stall !== 1'b1) begin errors++; $display("[TB] FAIL hold_stall got %0b exp 1", stall); end
    tick();
    checks++; if (ex_valid !== 1'b1 || ex_rd !== 5'd6 || ex_is_load !== 1'b1 || ex_pc !== 32'h300) begin errors++; $display("[TB] FAIL hold_keep got v=%0b rd=%0d l=%0b pc=%h exp 1/6/1/300", ex_valid, ex_rd, ex_is_load, ex_pc); end
    checks++; if (stall_count !== 16'(expCount)) begin errors++; $display("[TB] FAIL hold_count got %0d exp %0d", stall_count, expCount); end
    hold = 1'b0;
    #1;
    checks++; if (stall !== 1'b1) begin errors++; $display("[TB] FAIL post_hold_lu got %0b exp 1", stall); end
    tick(); expCount++;
    checks++; if (ex_valid !== 1'b0 || stall_count !== 16'(expCount)) begin errors++; $display("[TB] FAIL post_hold_bubble got v=%0b cnt=%0d exp 0/%0d", ex_valid, stall_count, expCount); end
  endtask

  task test_saturation;
    for (int i = 0; i < 20; i++) begin
      in_ins = INS_LW;
      tick();
      in_ins = INS_ADD;
      tick(); expCount++;
    end
    expSat = (expCount > 15) ? 4'hF : 4'(expCount);
    checks++; if (s_stall_count !== expSat) begin errors++; $display("[TB] FAIL sat_count got %h exp %h", s_stall_count, expSat); end
    checks++; if (stall_count !== 16'(expCount)) begin errors++; $display("[TB] FAIL main_count got %0d exp %0d", stall_count, expCount); end
    in_ins = INS_LW;
    tick();
    in_ins = INS_ADD;
    tick(); expCount++;
    checks++; if (s_stall_count !== 4'hF) begin errors++; $display("[TB] FAIL sat_hold got %h exp F", s_stall_count); end
  endtask

  task test_reset_mid_stall;
    in_ins = INS_LW; in_pc = 32'h400;
    tick();
    in_ins = INS_ADD;
    #1;
    checks++; if (stall !== 1'b1) begin errors++; $display("[TB] FAIL pre_rst_stall got %0b exp 1", stall); end
    rst_n = 1'b0;
    tick();
    checks++; if (ex_valid !== 1'b0 || ex_pc !== 32'h0 || ex_a !== 32'h0 || ex_imm !== 32'h0) begin errors++; $display("[TB] FAIL rst_data got v=%0b pc=%h a=%h imm=%h exp all 0", ex_valid, ex_pc, ex_a, ex_imm); end
    checks++; if (ex_rd !== 5'd0 || ex_opcode !== 7'd0 || ex_is_load !== 1'b0 || ex_regwrite !== 1'b0) begin errors++; $display("[TB] FAIL rst_ctl got rd=%0d op=%h l=%0b w=%0b exp all 0", ex_rd, ex_opcode, ex_is_load, ex_regwrite); end
    checks++; if (stall_count !== 16'h0 || s_stall_count !== 4'h0) begin errors++; $display("[TB] FAIL rst_count got %h/%h exp 0/0", stall_count, s_stall_count); end
    rst_n = 1'b1;
    applyIdle();
    tick();
  endtask

  initial begin
    test_reset();
    test_addi();
    test_load_use();
    test_bypass();
    test_branch();
    test_imm_formats();
    test_flush_hold();
    test_saturation();
    test_reset_mid_stall();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
